mult_sched: RTL and testbench

Shared-multiplier scheduler. Arbitrates two requesters (CPU execute stage on port 0, guidance-calculation unit on port 1) onto one instance of the team's combinational 32x32 `multiplier` block. Operands are registered into the multiplier and the result is held for the winning requester until it acknowledges. The registered operands let the multiplier's long combinational path be constrained as a `MUL_CYCLES` multicycle path.

---
 rtl/mult_sched.sv | 144 ++++++++++++++
 tb/tb_mult_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
// Two-port scheduler sharing one combinational 32x32 signed multiplier.
// Operands are registered so the multiplier path can be a MUL_CYCLES multicycle path.

module multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        ex
);
    logic signed [63:0] p;

    assign p  = $signed(a) * $signed(b);
    // Sign bit comes from the full product; ex flags any loss in the upper bits.
    assign c  = {p[63], p[30:0]};
    assign ex = !((p[63:31] == '0) || (p[63:31] == '1));
endmodule

module mult_sched #(
    parameter int unsigned MUL_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    output logic        res0_valid,
    output logic [31:0] res0_c,
    output logic        res0_ex,
    input  logic        res0_ack,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        res1_valid,
    output logic [31:0] res1_c,
    output logic        res1_ex,
    input  logic        res1_ack,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        owner;
    logic        last_grant;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res_c;
    logic        res_ex;
    logic [31:0] mul_c;
    logic        mul_ex;
    logic        grant;
    logic        accept;
    logic        owner_ack;

    multiplier u_mul (
        .a  (op_a),
        .b  (op_b),
        .c  (mul_c),
        .ex (mul_ex)
    );

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = reset && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = reset && (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign owner_ack  = owner ? res1_ack : res0_ack;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = MUL;
            MUL:     if (cnt == 4'd0) next_state = HOLD;
            HOLD:    if (owner_ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            res_c      <= 32'd0;
            res_ex     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant ? req1_a : req0_a;
                        op_b       <= grant ? req1_b : req0_b;
                        owner      <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_INIT;
                    end
                end
                MUL: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_c  <= mul_c;
                        res_ex <= mul_ex;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res0_valid = (state == HOLD) && !owner;
    assign res1_valid = (state == HOLD) && owner;
    assign res0_c     = res_c;
    assign res1_c     = res_c;
    assign res0_ex    = res_ex;
    assign res1_ex    = res_ex;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_mult_sched.sv
// Directed bench: fast instance (MUL_CYCLES=1) and slow instance (MUL_CYCLES=3)
// share stimulus; each test resets both and checks one of them.

module tb_mult_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        res0_ack = 1'b0, res1_ack = 1'b0;

    logic        f_ready0, f_ready1, f_res0_valid, f_res1_valid, f_ex0, f_ex1, f_busy;
    logic [31:0] f_c0, f_c1;
    logic        s_ready0, s_ready1, s_res0_valid, s_res1_valid, s_ex0, s_ex1, s_busy;
    logic [31:0] s_c0, s_c1;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mult_sched #(.MUL_CYCLES(1)) dut_fast (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(f_ready0),
        .res0_valid(f_res0_valid), .res0_c(f_c0), .res0_ex(f_ex0), .res0_ack(res0_ack),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(f_ready1),
        .res1_valid(f_res1_valid), .res1_c(f_c1), .res1_ex(f_ex1), .res1_ack(res1_ack),
        .busy(f_busy)
    );

    mult_sched #(.MUL_CYCLES(3)) dut_slow (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s_ready0),
        .res0_valid(s_res0_valid), .res0_c(s_c0), .res0_ex(s_ex0), .res0_ack(res0_ack),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s_ready1),
        .res1_valid(s_res1_valid), .res1_c(s_c1), .res1_ex(s_ex1), .res1_ack(res1_ack),
        .busy(s_busy)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res0_ack   = 1'b0;
        res1_ack   = 1'b0;
        reset      = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset      = 1'b0;
        #1;
        tests++;
        if ({f_ready0, f_ready1, f_res0_valid, f_res1_valid, f_busy} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs got %b want 00000",
                     {f_ready0, f_ready1, f_res0_valid, f_res1_valid, f_busy});
        end
        tests++;
        if (f_c0 !== 32'd0 || f_ex0 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_result got c=%h ex=%b want 0/0", f_c0, f_ex0);
        end
        apply_reset();
    endtask

    task automatic do_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_c, input logic exp_ex, input string name);
        logic rdy, other_rdy, vld, other_vld, ex;
        logic [31:0] c;
        apply_reset();
        if (port) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        rdy       = port ? f_ready1 : f_ready0;
        other_rdy = port ? f_ready0 : f_ready1;
        tests++;
        if (rdy !== 1'b1 || other_rdy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_ready got %b/%b want 1/0", name, rdy, other_rdy);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        tests++;
        if (f_busy !== 1'b1 || f_res0_valid !== 1'b0 || f_res1_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_mul got busy=%b v0=%b v1=%b want 1/0/0",
                     name, f_busy, f_res0_valid, f_res1_valid);
        end
        step();
        vld       = port ? f_res1_valid : f_res0_valid;
        other_vld = port ? f_res0_valid : f_res1_valid;
        c         = port ? f_c1 : f_c0;
        ex        = port ? f_ex1 : f_ex0;
        tests++;
        if (vld !== 1'b1 || other_vld !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_valid got %b/%b want 1/0", name, vld, other_vld);
        end
        tests++;
        if (c !== exp_c || ex !== exp_ex) begin
            fails++;
            $display("[TB] FAIL %s_result got c=%h ex=%b want c=%h ex=%b", name, c, ex, exp_c, exp_ex);
        end
        if (port) res1_ack = 1'b1; else res0_ack = 1'b1;
        step();
        res0_ack = 1'b0;
        res1_ack = 1'b0;
        tests++;
        if (f_busy !== 1'b0 || f_res0_valid !== 1'b0 || f_res1_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s_release got busy=%b v0=%b v1=%b want 0/0/0",
                     name, f_busy, f_res0_valid, f_res1_valid);
        end
    endtask

    task automatic test_arith;
        do_op(1'b0, 32'd3, 32'd4, 32'd12, 1'b0, "p0_small");
        do_op(1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, "p1_negative");
        do_op(1'b0, 32'h7FFF_FFFF, 32'd2, 32'h7FFF_FFFE, 1'b1, "p0_overflow");
    endtask

    task automatic test_back_to_back;
        int grants[$];
        int gcyc[$];
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd7;
        #1;
        for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
            if (s_ready0) begin grants.push_back(0); gcyc.push_back(cyc); end
            if (s_ready1) begin grants.push_back(1); gcyc.push_back(cyc); end
            if (s_res0_valid || s_res1_valid) begin
                tests++;
                if (grants.size() == 0 || s_res0_valid !== (grants[$] == 0) ||
                    s_res1_valid !== (grants[$] == 1)) begin
                    fails++;
                    $display("[TB] FAIL b2b_owner cyc=%0d got v0=%b v1=%b want owner=%0d",
                             cyc, s_res0_valid, s_res1_valid, grants.size() ? grants[$] : -1);
                end
                tests++;
                if (s_c0 !== (s_res0_valid ? 32'd6 : 32'd35)) begin
                    fails++;
                    $display("[TB] FAIL b2b_result cyc=%0d got %0d want %0d",
                             cyc, s_c0, s_res0_valid ? 6 : 35);
                end
            end
            res0_ack = s_res0_valid;
            res1_ack = s_res1_valid;
            step();
        end
        res0_ack = 1'b0; res1_ack = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests++;
        if (grants.size() != 4) begin
            fails++;
            $display("[TB] FAIL b2b_count got %0d grants want 4", grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            tests++;
            if (grants[i] != i % 2) begin
                fails++;
                $display("[TB] FAIL b2b_order grant %0d got port %0d want %0d", i, grants[i], i % 2);
            end
            if (i > 0) begin
                tests++;
                if (gcyc[i] - gcyc[i-1] != 5) begin
                    fails++;
                    $display("[TB] FAIL b2b_spacing grant %0d got %0d want 5", i, gcyc[i] - gcyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_hold_stall;
        int bad = 0;
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd7;
        #1;
        tests++;
        if (f_ready0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_accept got ready0=%b want 1", f_ready0);
        end
        step();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9;
        step();
        res1_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests++;
            if (f_res0_valid !== 1'b1 || f_c0 !== 32'd42 || f_ex0 !== 1'b0 || f_busy !== 1'b1 ||
                f_ready1 !== 1'b0 || f_res1_valid !== 1'b0) begin
                fails++;
                bad++;
                $display("[TB] FAIL stall_hold cyc=%0d got v0=%b c=%0d ex=%b busy=%b rdy1=%b v1=%b want 1/42/0/1/0/0",
                         i, f_res0_valid, f_c0, f_ex0, f_busy, f_ready1, f_res1_valid);
            end
            step();
        end
        res1_ack = 1'b0;
        res0_ack = 1'b1;
        step();
        res0_ack = 1'b0;
        #1;
        tests++;
        if (f_busy !== 1'b0 || f_ready1 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_release got busy=%b rdy1=%b want 0/1", f_busy, f_ready1);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3;
        req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4;
        #1;
        tests++;
        if (s_ready0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rmid_accept got ready0=%b want 1", s_ready0);
        end
        step();
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({s_ready0, s_ready1, s_res0_valid, s_res1_valid, s_busy} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL rmid_async got %b want 00000",
                     {s_ready0, s_ready1, s_res0_valid, s_res1_valid, s_busy});
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (s_res0_valid !== 1'b0 || s_res1_valid !== 1'b0 || s_busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL rmid_ghost cyc=%0d got v0=%b v1=%b busy=%b want 0/0/0",
                         i, s_res0_valid, s_res1_valid, s_busy);
            end
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        tests++;
        if (s_ready0 !== 1'b1 || s_ready1 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rmid_tie got %b/%b want 1/0", s_ready0, s_ready1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_hold_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
